spi_reg_bridge: RTL and testbench
=================================

# spi_reg_bridge

Byte-level command decoder and register bank that sits directly downstream of the mode-0 SPI slave. It consumes each received byte (`rx_dv`/`rx_byte`) and drives the slave's transmit byte (`tx_byte`). This turns an SPI frame into register reads and writes on a bank of 8-bit configuration registers. The bank is exposed to the core as a flat bus, with a one-cycle write strobe per byte written.

## Interface
Parameters:
- `NUM_REGS`, 16: number of 8-bit registers; legal range 1..64.
- `DEV_ID`, 8'hA5: byte returned to the master while the command byte is shifted.
- `RESET_VAL`, 8'h00: reset value of every register.

Ports:
- `clk`, in, 1: system clock, same clock as the SPI slave.
- `resetn`, in, 1: asynchronous active-low reset.
- `spi_cs`, in, 1: raw SPI chip select, active low; synchronized internally.
- `rx_dv`, in, 1: one-cycle pulse from the slave, meaning a byte has been received.
- `rx_byte`, in, 8: received byte; valid while `rx_dv` = 1.
- `tx_byte`, out, 8: byte the slave loads on CS fall and on `rx_dv`; combinational.
- `regs_flat`, out, NUM_REGS*8: register bank; reg *i* occupies bits [8i+7:8i].
- `wr_stb`, out, 1: one-cycle pulse when a register has been written.
- `wr_addr`, out, 6: address of the last write.
- `wr_data`, out, 8: data of the last write.
- `frame_active`, out, 1: high while the synchronized CS is low.

## Operation
- Command byte: bit7 = WR (1 = write, 0 = read); bit6 = INC (auto-increment); bits[5:0] = ADDR.
- Frame structure: the first byte after CS fall is the command; every later byte in the frame is a data byte.
- `spi_cs` passes through a 2-FF synchronizer, matching the slave's CS latency, so frame boundaries align with the slave.

State machine:
- `ST_IDLE`: CS high. Any `rx_dv` is ignored. Moves to `ST_CMD` when the synchronized CS goes low.
- `ST_CMD`: on `rx_dv`, latch WR, INC and ADDR into `addr_q`, then move to `ST_DATA`.
- `ST_DATA`, write: on `rx_dv`, if `addr_q` < NUM_REGS then `reg[addr_q]` <= `rx_byte` and `wr_stb` pulses with `wr_addr`/`wr_data`. If INC = 1, `addr_q` <= (`addr_q` + 1) mod NUM_REGS.
- `ST_DATA`, read: on `rx_dv`, the received byte is discarded. If INC = 1, `addr_q` advances as for writes.
- Any state: synchronized CS high forces `ST_IDLE` on the next edge. This aborts the frame; a partially shifted byte produces no `rx_dv` and no write.
- Simultaneous `rx_dv` with synchronized CS high: the abort wins, and `rx_dv` is ignored.
- Out-of-range ADDR (≥ NUM_REGS): writes are dropped with no `wr_stb`; reads return 8'h00. With INC = 1, the address still wraps modulo NUM_REGS.

`tx_byte` mux, combinational:
- `ST_IDLE` or `ST_CMD` with `rx_dv` = 0: `DEV_ID`.
- `ST_CMD` with `rx_dv` = 1: `reg[rx_byte[5:0]]`, or 8'h00 if out of range. This is the byte for the first data slot.
- `ST_DATA` with `rx_dv` = 1: the next address's register if INC = 1, else `reg[addr_q]`.
- `ST_DATA` with `rx_dv` = 0: `reg[addr_q]`.
- During write frames `tx_byte` follows the same rule, so the master reads back the old register contents.

## Timing
- Reset values: state `ST_IDLE`, `addr_q` = 0, every register = `RESET_VAL`, `wr_stb` = 0, `wr_addr` = 0, `wr_data` = 0, `frame_active` = 0, `tx_byte` = `DEV_ID`.
- `regs_flat` updates on the clock edge where `rx_dv` = 1, so the new value is visible the next cycle.
- `wr_stb` is high for exactly the cycle after that edge.
- `tx_byte` is valid in the same cycle as `rx_dv`, because the slave samples it on that edge; there is zero-cycle latency from `rx_byte` to `tx_byte`.
- `frame_active` lags `spi_cs` by 2 clk.
- Back-to-back `rx_dv` pulses are spaced ≥ 8 SPI clocks apart, so the bridge needs no back-pressure.
- Reset asserted mid-frame clears everything immediately; the bridge resumes at the next CS fall.

## Structure
- Shared package `spi_reg_pkg`: state encoding (`ST_IDLE`/`ST_CMD`/`ST_DATA`), command bit positions (`CMD_WR` = 7, `CMD_INC` = 6, `CMD_ADDR` = 5:0), and the default `DEV_ID`.
- One sub-module, `sync_2ff`: a generic 2-flop synchronizer with async active-low reset, reset value 1 for CS.
- The register bank and `tx_byte` mux stay inline.

## Test plan
- Reset, then a CS-low frame with a single dummy byte → MISO returns 8'hA5; no `wr_stb`; `regs_flat` all 8'h00.
- Write frame 8'h83, 8'h5A → `reg[3]` = 8'h5A; one `wr_stb` with `wr_addr` = 3, `wr_data` = 8'h5A. A following read frame 8'h03, 8'h00 → second MISO byte = 8'h5A.
- Auto-increment write 8'hCF, 8'h11, 8'h22 with NUM_REGS = 16 → `reg[15]` = 8'h11, `reg[0]` = 8'h22 (wrap); two `wr_stb` pulses.
- Out-of-range write 8'hA0 (addr 32), 8'hFF → no `wr_stb`; bank unchanged. Read 8'h20 → data byte 8'h00.
- CS raised after 4 bits of the data byte in a write frame → no write, state returns to `ST_IDLE`, and the next frame's first MISO byte is 8'hA5.
- `resetn` pulsed low mid auto-increment read → all outputs return to their reset values asynchronously; the next frame decodes normally.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bridge: FSM states, command byte layout, defaults.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_e;

  // Command byte layout
  localparam int unsigned CMD_WR       = 7;
  localparam int unsigned CMD_INC      = 6;
  localparam int unsigned CMD_ADDR_MSB = 5;
  localparam int unsigned CMD_ADDR_LSB = 0;
  localparam int unsigned ADDR_W       = 6;

  localparam logic [7:0] DEV_ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset and selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift toward the clk domain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// Byte-level SPI command decoder with an 8-bit register bank and a combinational MISO byte mux.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [7:0]  DEV_ID    = DEV_ID_DEFAULT,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  spi_cs,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            tx_byte,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_stb,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic                  frame_active
);

  localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

  logic              cs_sync;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic              inc_q;
  logic [7:0]        regs_q [NUM_REGS];
  logic              wr_stb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  logic [ADDR_W:0]   addr_inc;
  logic [ADDR_W:0]   addr_wrap;
  logic [ADDR_W-1:0] addr_next;
  logic              addr_in_range;
  logic              do_cmd;
  logic              do_data;
  logic              do_write;

  // Full 64-entry read view; unimplemented addresses read as zero
  logic [7:0]        rd_tab [2**ADDR_W];

  // CS synchronizer resets high so a reset never looks like a frame start
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .resetn(resetn),
    .d     (spi_cs),
    .q     (cs_sync)
  );

  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_rd_tab
    if (i < NUM_REGS) begin : g_impl
      assign rd_tab[i] = regs_q[i];
    end else begin : g_zero
      assign rd_tab[i] = 8'h00;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = regs_q[i];
  end

  assign addr_inc      = {1'b0, addr_q} + 1'b1;
  assign addr_wrap     = addr_inc % NumRegsW;
  assign addr_next     = addr_wrap[ADDR_W-1:0];
  assign addr_in_range = {1'b0, addr_q} < NumRegsW;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, byte qualifiers and MISO mux; CS high overrides any rx_dv
  always_comb begin
    state_d  = state_q;
    do_cmd   = 1'b0;
    do_data  = 1'b0;
    tx_byte  = DEV_ID;
    if (cs_sync) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          do_cmd = rx_dv;
          if (rx_dv) state_d = ST_DATA;
        end
        ST_DATA: do_data = rx_dv;
        default: state_d = ST_IDLE;
      endcase
    end
    unique case (state_q)
      ST_CMD:  if (rx_dv) tx_byte = rd_tab[rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]];
      ST_DATA: tx_byte = (rx_dv && inc_q) ? rd_tab[addr_next] : rd_tab[addr_q];
      default: tx_byte = DEV_ID;
    endcase
  end

  assign do_write = do_data && wr_q && addr_in_range;

  // Command latch, address pointer and write-report outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      wr_q      <= 1'b0;
      inc_q     <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      wr_stb_q <= do_write;
      if (do_cmd) begin
        wr_q   <= rx_byte[CMD_WR];
        inc_q  <= rx_byte[CMD_INC];
        addr_q <= rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
      end else if (do_data && inc_q) begin
        addr_q <= addr_next;
      end
      if (do_write) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
    end
  end

  // Register bank
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (do_write && addr_q == ADDR_W'(i)) regs_q[i] <= rx_byte;
      end
    end
  end

  assign wr_stb       = wr_stb_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_active = ~cs_sync;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge driven at byte level.
module tb_spi_reg_bridge;

  localparam int unsigned NUM_REGS = 16;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  spi_cs;
  logic                  rx_dv;
  logic [7:0]            rx_byte;
  logic [7:0]            tx_byte;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  wr_stb;
  logic [5:0]            wr_addr;
  logic [7:0]            wr_data;
  logic                  frame_active;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;

  spi_reg_bridge #(
    .NUM_REGS (NUM_REGS),
    .DEV_ID   (8'hA5),
    .RESET_VAL(8'h00)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .spi_cs      (spi_cs),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .tx_byte     (tx_byte),
    .regs_flat   (regs_flat),
    .wr_stb      (wr_stb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  // Counts every cycle wr_stb is high, so a stretched pulse shows as an extra count
  always @(negedge clk) begin
    if (wr_stb === 1'b1) stb_cnt++;
  end

  function automatic logic [7:0] get_reg(input int i);
    return regs_flat[8*i +: 8];
  endfunction

  task automatic frame_start();
    @(negedge clk) spi_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk) spi_cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One received byte: tx is the MISO byte loaded on this rx_dv, stb is wr_stb the next cycle
  task automatic send_byte(input logic [7:0] b, output logic [7:0] tx, output logic stb);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    #1 tx = tx_byte;
    @(negedge clk);
    rx_dv = 1'b0;
    stb   = wr_stb;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    spi_cs  = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_stb !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr: stb=%b addr=%0d data=%h, required 0/0/00", wr_stb, wr_addr, wr_data);
    end
    checks++;
    if (frame_active !== 1'b0 || tx_byte !== 8'hA5) begin
      errors++;
      $display("FAIL reset_out: frame_active=%b tx=%h, required 0/a5", frame_active, tx_byte);
    end
    checks++;
    if (regs_flat !== '0) begin
      errors++;
      $display("FAIL reset_regs: got %h, required all zero", regs_flat);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dev_id();
    logic [7:0] tx;
    logic stb;
    int cnt0;
    cnt0 = stb_cnt;
    frame_start();
    checks++;
    if (frame_active !== 1'b1 || tx_byte !== 8'hA5) begin
      errors++;
      $display("FAIL dev_id: frame_active=%b tx=%h, required 1/a5", frame_active, tx_byte);
    end
    send_byte(8'h00, tx, stb);
    frame_end();
    checks++;
    if (stb_cnt - cnt0 !== 0 || regs_flat !== '0) begin
      errors++;
      $display("FAIL dev_id_nowrite: stb_cycles=%0d regs=%h, required 0/zero", stb_cnt - cnt0,
               regs_flat);
    end
    checks++;
    if (frame_active !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: frame_active=%b, required 0", frame_active);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] tx;
    logic stb;
    int cnt0;
    cnt0 = stb_cnt;
    frame_start();
    send_byte(8'h83, tx, stb);
    send_byte(8'h5A, tx, stb);
    checks++;
    if (tx !== 8'h00 || stb !== 1'b1) begin
      errors++;
      $display("FAIL write_slot: tx=%h stb=%b, required 00/1", tx, stb);
    end
    frame_end();
    checks++;
    if (get_reg(3) !== 8'h5A || stb_cnt - cnt0 !== 1 || wr_addr !== 6'd3 || wr_data !== 8'h5A) begin
      errors++;
      $display("FAIL write_reg3: reg=%h stb_cycles=%0d addr=%0d data=%h, required 5a/1/3/5a",
               get_reg(3), stb_cnt - cnt0, wr_addr, wr_data);
    end
    frame_start();
    send_byte(8'h03, tx, stb);
    checks++;
    if (tx !== 8'h5A) begin
      errors++;
      $display("FAIL read_reg3: tx=%h, required 5a", tx);
    end
    send_byte(8'h00, tx, stb);
    frame_end();
  endtask

  task automatic test_auto_inc();
    logic [7:0] tx;
    logic stb;
    int cnt0;
    cnt0 = stb_cnt;
    frame_start();
    send_byte(8'hCF, tx, stb);
    send_byte(8'h11, tx, stb);
    send_byte(8'h22, tx, stb);
    frame_end();
    checks++;
    if (get_reg(15) !== 8'h11 || get_reg(0) !== 8'h22 || stb_cnt - cnt0 !== 2) begin
      errors++;
      $display("FAIL inc_write: r15=%h r0=%h stb_cycles=%0d, required 11/22/2", get_reg(15),
               get_reg(0), stb_cnt - cnt0);
    end
    checks++;
    if (wr_addr !== 6'd0 || wr_data !== 8'h22) begin
      errors++;
      $display("FAIL inc_last: addr=%0d data=%h, required 0/22", wr_addr, wr_data);
    end
    frame_start();
    send_byte(8'h4F, tx, stb);
    checks++;
    if (tx !== 8'h11) begin
      errors++;
      $display("FAIL inc_read0: tx=%h, required 11", tx);
    end
    send_byte(8'h00, tx, stb);
    checks++;
    if (tx !== 8'h22) begin
      errors++;
      $display("FAIL inc_read_wrap: tx=%h, required 22", tx);
    end
    frame_end();
  endtask

  task automatic test_out_of_range();
    logic [7:0] tx;
    logic stb;
    logic [NUM_REGS*8-1:0] snap;
    int cnt0;
    cnt0 = stb_cnt;
    snap = regs_flat;
    frame_start();
    send_byte(8'hA0, tx, stb);
    send_byte(8'hFF, tx, stb);
    frame_end();
    checks++;
    if (stb_cnt - cnt0 !== 0 || regs_flat !== snap) begin
      errors++;
      $display("FAIL oor_write: stb_cycles=%0d regs=%h, required 0/%h", stb_cnt - cnt0, regs_flat,
               snap);
    end
    frame_start();
    send_byte(8'h20, tx, stb);
    checks++;
    if (tx !== 8'h00) begin
      errors++;
      $display("FAIL oor_read: tx=%h, required 00", tx);
    end
    frame_end();
    // addr 47 with INC wraps to 48 mod 16 = 0
    frame_start();
    send_byte(8'h6F, tx, stb);
    send_byte(8'h00, tx, stb);
    checks++;
    if (tx !== 8'h22) begin
      errors++;
      $display("FAIL oor_inc_wrap: tx=%h, required 22", tx);
    end
    frame_end();
  endtask

  task automatic test_abort();
    logic [7:0] tx;
    logic stb;
    int cnt0;
    cnt0 = stb_cnt;
    frame_start();
    send_byte(8'h83, tx, stb);
    repeat (4) @(negedge clk);
    frame_end();
    checks++;
    if (get_reg(3) !== 8'h5A || stb_cnt - cnt0 !== 0 || frame_active !== 1'b0 || tx_byte !== 8'hA5)
    begin
      errors++;
      $display("FAIL abort: r3=%h stb_cycles=%0d fa=%b tx=%h, required 5a/0/0/a5", get_reg(3),
               stb_cnt - cnt0, frame_active, tx_byte);
    end
    frame_start();
    checks++;
    if (tx_byte !== 8'hA5) begin
      errors++;
      $display("FAIL abort_next: tx=%h, required a5", tx_byte);
    end
    frame_end();
    // rx_dv lands in the cycle the synchronized CS is already high
    frame_start();
    send_byte(8'h83, tx, stb);
    @(negedge clk) spi_cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = 8'h77;
    @(negedge clk) rx_dv = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (get_reg(3) !== 8'h5A || stb_cnt - cnt0 !== 0) begin
      errors++;
      $display("FAIL abort_wins: r3=%h stb_cycles=%0d, required 5a/0", get_reg(3), stb_cnt - cnt0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] tx;
    logic stb;
    int cnt0;
    frame_start();
    send_byte(8'h4F, tx, stb);
    send_byte(8'h00, tx, stb);
    @(negedge clk) resetn = 1'b0;
    #1;
    checks++;
    if (regs_flat !== '0 || frame_active !== 1'b0 || tx_byte !== 8'hA5 || wr_addr !== 6'd0 ||
        wr_data !== 8'h00 || wr_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: regs=%h fa=%b tx=%h addr=%0d data=%h stb=%b, required zero/0/a5/0/00/0",
               regs_flat, frame_active, tx_byte, wr_addr, wr_data, wr_stb);
    end
    spi_cs = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    cnt0 = stb_cnt;
    frame_start();
    send_byte(8'h81, tx, stb);
    checks++;
    if (tx !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_cmd: tx=%h, required 00", tx);
    end
    send_byte(8'h3C, tx, stb);
    frame_end();
    checks++;
    if (get_reg(1) !== 8'h3C || stb_cnt - cnt0 !== 1 || wr_addr !== 6'd1 || wr_data !== 8'h3C) begin
      errors++;
      $display("FAIL post_reset_write: r1=%h stb_cycles=%0d addr=%0d data=%h, required 3c/1/1/3c",
               get_reg(1), stb_cnt - cnt0, wr_addr, wr_data);
    end
  endtask

  initial begin
    test_reset();
    test_dev_id();
    test_write_read();
    test_auto_inc();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
